// File: rtl/snn_out_pkg.sv
// rtl/snn_out_pkg.sv - shared types and packet helpers for the output collector
// Holds default field widths, the tick-boundary FSM state type and the
// functions that split a grid packet {axon, tick} into its fields.
package snn_out_pkg;

   localparam int DEF_AXON_BITS = 8;
   localparam int DEF_TICK_BITS = 4;
   localparam int PKT_W         = DEF_AXON_BITS + DEF_TICK_BITS;

   // Helpers work on a wide container so any AXON_BITS/TICK_BITS pair fits;
   // callers zero-extend in and truncate out.
   localparam int PKT_MAX_W     = 64;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } fsm_state_t;

   function automatic logic [PKT_MAX_W-1:0] pkt_axon(input logic [PKT_MAX_W-1:0] pkt,
                                                     input int                   tick_bits);
      return pkt >> tick_bits;
   endfunction

   function automatic logic [PKT_MAX_W-1:0] pkt_tick(input logic [PKT_MAX_W-1:0] pkt,
                                                     input int                   tick_bits);
      return pkt & ((64'd1 << tick_bits) - 64'd1);
   endfunction

endpackage

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - parametrised first-word-fall-through synchronous FIFO
// Ports: clk, reset (async, active-high), wr_en/wr_data push, rd_en pop,
// rd_data head entry (zero while empty), level exact occupancy 0..DEPTH,
// full, empty. The caller never pushes when full without a same-cycle pop
// and never pops when empty.
module out_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   // Storage is not reset; emptiness gates the read port instead.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (wr_en) wptr <= wptr + AW'(1);
         if (rd_en) rptr <= rptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign rd_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/output_collector.sv
// rtl/output_collector.sv - round-robin collector of grid-edge spike packets
// Drains NUM_CHANNELS FWFT edge buffers (in_empty/in_ren) into one FWFT FIFO
// presented as a valid/ready stream, and pulses tick_done once every packet
// of a tick has left the grid and been taken by the host.
// Ports: clk, reset (async, active-high), in_data/in_empty/in_ren per-channel
// edge ports, out_data/out_valid/out_ready host stream, tick_end in,
// tick_done out, fifo_level occupancy.
// Build option OUTPUT_COLLECTOR_TICK_TAG_EN: when defined out_data carries
// {axon, tick}; otherwise only the axon field is kept.
module output_collector
   import snn_out_pkg::*;
#(
   parameter int  NUM_CHANNELS = 4,
   parameter int  AXON_BITS    = DEF_AXON_BITS,
   parameter int  TICK_BITS    = DEF_TICK_BITS,
   parameter int  FIFO_DEPTH   = 8,
`ifdef OUTPUT_COLLECTOR_TICK_TAG_EN
   localparam int OUT_W        = AXON_BITS + TICK_BITS,
`else
   localparam int OUT_W        = AXON_BITS,
`endif
   localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [NUM_CHANNELS*(AXON_BITS+TICK_BITS)-1:0] in_data,
   input  logic [NUM_CHANNELS-1:0]                    in_empty,
   output logic [NUM_CHANNELS-1:0]                    in_ren,
   output logic [OUT_W-1:0]                           out_data,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   input  logic                                       tick_end,
   output logic                                       tick_done,
   output logic [LVL_W-1:0]                           fifo_level
);

   localparam int CH_W  = AXON_BITS + TICK_BITS;
   localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] gnt_idx;
   logic             found;
   logic [CH_W-1:0]  sel_pkt;
   logic             grant;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [OUT_W-1:0] fifo_wdata;
   logic [AXON_BITS-1:0] sel_axon;

   // First non-empty channel at or after the pointer, wrapping.
   always_comb begin
      int c;
      c       = 0;
      found   = 1'b0;
      gnt_idx = '0;
      sel_pkt = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         c = (int'(rr_ptr) + i) % NUM_CHANNELS;
         if (!found && !in_empty[c]) begin
            found   = 1'b1;
            gnt_idx = PTR_W'(c);
            sel_pkt = in_data[c*CH_W +: CH_W];
         end
      end
   end

   assign pop   = out_valid & out_ready;
   // A pop frees a slot this same edge, so a full FIFO can still take a
   // refill. Reset forces in_ren low without waiting for a clock.
   assign grant = found & (!fifo_full | pop) & !reset;

   always_comb begin
      in_ren = '0;
      if (grant) in_ren[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (grant) begin
         rr_ptr <= (gnt_idx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   assign sel_axon = AXON_BITS'(pkt_axon(PKT_MAX_W'(sel_pkt), TICK_BITS));

`ifdef OUTPUT_COLLECTOR_TICK_TAG_EN
   assign fifo_wdata = {sel_axon, TICK_BITS'(pkt_tick(PKT_MAX_W'(sel_pkt), TICK_BITS))};
`else
   assign fifo_wdata = sel_axon;
`endif

   out_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (grant),
      .wr_data (fifo_wdata),
      .rd_en   (pop),
      .rd_data (out_data),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_valid = !fifo_empty;

   fsm_state_t state, state_nxt;
   logic       pend, pend_nxt;
   logic       drained;

   assign drained = (&in_empty) & fifo_empty & !grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      tick_done = 1'b0;
      case (state)
         ST_RUN: begin
            if (tick_end) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            pend_nxt = pend | tick_end;
            if (drained) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            tick_done = 1'b1;
            // One outstanding boundary goes straight back to DRAIN; a second
            // one arriving now stays latched for the following round.
            if (pend | tick_end) begin
               state_nxt = ST_DRAIN;
               pend_nxt  = pend & tick_end;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            pend_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_output_collector.sv
// tb/tb_output_collector.sv - directed self-checking bench for output_collector
module tb_output_collector;

   localparam int NC    = 4;
   localparam int AW    = 8;
   localparam int TW    = 4;
   localparam int DEPTH = 8;
   localparam int CW    = AW + TW;
`ifdef OUTPUT_COLLECTOR_TICK_TAG_EN
   localparam int OW    = CW;
   localparam logic [31:0] SINGLE_EXP = 32'h5A3;
`else
   localparam int OW    = AW;
   localparam logic [31:0] SINGLE_EXP = 32'h5A;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [NC*CW-1:0] in_data;
   logic [NC-1:0]   in_empty;
   logic [NC-1:0]   in_ren;
   logic [OW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;
   logic            tick_end;
   logic            tick_done;
   logic [3:0]      fifo_level;

   always #5 clk = ~clk;

   output_collector #(
      .NUM_CHANNELS (NC),
      .AXON_BITS    (AW),
      .TICK_BITS    (TW),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_empty   (in_empty),
      .in_ren     (in_ren),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .tick_end   (tick_end),
      .tick_done  (tick_done),
      .fifo_level (fifo_level)
   );

   logic [CW-1:0] chq [NC][$];
   logic [OW-1:0] exp_q [$];

   int n_chk  = 0;
   int n_pass = 0;
   int n_pop  = 0;

   logic [NC-1:0] ren_s;
   logic          val_s;
   logic [OW-1:0] dat_s;
   logic [3:0]    lvl_s;
   logic          done_s;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [OW-1:0] exp_of(input logic [CW-1:0] p);
`ifdef OUTPUT_COLLECTOR_TICK_TAG_EN
      return OW'(p);
`else
      return p[CW-1:TW];
`endif
   endfunction

   task automatic drive_ch();
      for (int c = 0; c < NC; c++) begin
         if (chq[c].size() == 0) begin
            in_empty[c]           = 1'b1;
            in_data[c*CW +: CW]   = '0;
         end else begin
            in_empty[c]           = 1'b0;
            in_data[c*CW +: CW]   = chq[c][0];
         end
      end
   endtask

   // One clock: drive upstream heads at negedge, sample #1 later, score pops
   // and grants, then retire granted heads just after the posedge.
   task automatic step();
      @(negedge clk);
      drive_ch();
      #1;
      ren_s  = in_ren;
      val_s  = out_valid;
      dat_s  = out_data;
      lvl_s  = fifo_level;
      done_s = tick_done;
      if (val_s && out_ready) begin
         n_pop++;
         if (exp_q.size() == 0) chk("sb_extra_pop", 32'(1), 32'(0));
         else                   chk("sb_data", 32'(dat_s), 32'(exp_q.pop_front()));
      end
      for (int c = 0; c < NC; c++)
         if (ren_s[c] && chq[c].size() > 0) exp_q.push_back(exp_of(chq[c][0]));
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++)
         if (ren_s[c] && chq[c].size() > 0) void'(chq[c].pop_front());
   endtask

   task automatic flush();
      for (int c = 0; c < NC; c++) chq[c].delete();
      exp_q.delete();
      n_pop = 0;
      drive_ch();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      out_ready = 1'b0;
      tick_end  = 1'b0;
      flush();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pulses, early, zero_at, done_at, first_at, second_at;
      logic seen_v, seen_d;

      reset     = 1'b1;
      out_ready = 1'b0;
      tick_end  = 1'b0;
      in_data   = '0;
      in_empty  = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ren",   32'(in_ren),     32'(0));
      chk("rst_valid", 32'(out_valid),  32'(0));
      chk("rst_data",  32'(out_data),   32'(0));
      chk("rst_done",  32'(tick_done),  32'(0));
      chk("rst_level", 32'(fifo_level), 32'(0));
      reset = 1'b0;

      // single packet on channel 2
      chq[2].push_back({8'h5A, 4'h3});
      out_ready = 1'b1;
      step();
      chk("single_ren",      32'(ren_s), 32'h4);
      chk("single_lvl0",     32'(lvl_s), 32'(0));
      step();
      chk("single_valid",    32'(val_s), 32'(1));
      chk("single_data",     32'(dat_s), SINGLE_EXP);
      chk("single_lvl1",     32'(lvl_s), 32'(1));
      chk("single_ren_off",  32'(ren_s), 32'(0));
      step();
      chk("single_lvl_end",  32'(lvl_s), 32'(0));
      chk("single_val_end",  32'(val_s), 32'(0));

      // fairness: four loaded channels, host always ready
      do_reset();
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < 4; k++)
            chq[c].push_back(CW'({4'(c), 4'(k), 4'(k)}));
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("fair_grant", 32'(ren_s), 32'(1) << (i % 4));
      end
      repeat (3) step();
      chk("fair_count",  32'(n_pop),        32'(16));
      chk("fair_sb_end", 32'(exp_q.size()), 32'(0));

      // backpressure: fill to full, then one pop plus one refill per cycle
      do_reset();
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < 6; k++)
            chq[c].push_back(CW'({4'(c + 8), 4'(k), 4'(c)}));
      for (int i = 0; i < 10; i++) begin
         step();
         if (i < 8) chk("bp_fill_ren", 32'($countones(ren_s)), 32'(1));
         else       chk("bp_full_ren", 32'(ren_s),             32'(0));
      end
      chk("bp_level_full", 32'(lvl_s), 32'(8));
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("bp_level_hold", 32'(lvl_s),             32'(8));
         chk("bp_refill",     32'($countones(ren_s)), 32'(1));
      end
      repeat (10) step();
      chk("bp_total",  32'(n_pop),        32'(24));
      chk("bp_sb_end", 32'(exp_q.size()), 32'(0));

      // tick drain with five queued packets
      do_reset();
      for (int k = 0; k < 3; k++) chq[0].push_back(CW'({4'h1, 4'(k), 4'h7}));
      for (int k = 0; k < 2; k++) chq[1].push_back(CW'({4'h2, 4'(k), 4'h7}));
      repeat (6) step();
      chk("td_level", 32'(lvl_s), 32'(5));
      tick_end = 1'b1;
      step();
      tick_end = 1'b0;
      chk("td_no_early_done", 32'(done_s), 32'(0));
      out_ready = 1'b1;
      pulses = 0; early = 0; zero_at = -1; done_at = -1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done_s) begin
            pulses++;
            if (done_at < 0) done_at = i;
            if (lvl_s != 0) early++;
         end
         if (lvl_s == 0 && zero_at < 0) zero_at = i;
      end
      chk("td_pulses",     32'(pulses),  32'(1));
      chk("td_early",      32'(early),   32'(0));
      chk("td_zero_cycle", 32'(zero_at), 32'(5));
      chk("td_done_cycle", 32'(done_at), 32'(6));
      chk("td_pops",       32'(n_pop),   32'(5));

      // back-to-back ticks on an idle grid, second during DRAIN
      do_reset();
      out_ready = 1'b1;
      tick_end  = 1'b1;
      step();
      chk("b2b_done_a", 32'(done_s), 32'(0));
      step();
      chk("b2b_done_b", 32'(done_s), 32'(0));
      tick_end = 1'b0;
      pulses = 0; first_at = -1; second_at = -1;
      for (int j = 0; j < 8; j++) begin
         step();
         if (done_s) begin
            pulses++;
            if (first_at < 0) first_at = j;
            else if (second_at < 0) second_at = j;
         end
      end
      chk("b2b_pulses", 32'(pulses),    32'(2));
      chk("b2b_first",  32'(first_at),  32'(0));
      chk("b2b_second", 32'(second_at), 32'(2));

      // asynchronous reset while draining with four packets held
      do_reset();
      for (int k = 0; k < 4; k++) chq[3].push_back(CW'({4'h3, 4'(k), 4'h1}));
      repeat (5) step();
      chk("mr_level", 32'(lvl_s), 32'(4));
      tick_end = 1'b1;
      step();
      tick_end = 1'b0;
      step();
      chq[0].push_back(CW'({8'hEE, 4'h2}));
      drive_ch();
      #1;
      reset = 1'b1;
      #1;
      chk("mr_ren",   32'(in_ren),     32'(0));
      chk("mr_valid", 32'(out_valid),  32'(0));
      chk("mr_data",  32'(out_data),   32'(0));
      chk("mr_level0",32'(fifo_level), 32'(0));
      chk("mr_done",  32'(tick_done),  32'(0));
      flush();
      @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      seen_v = 1'b0;
      seen_d = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen_v |= val_s;
         seen_d |= done_s;
      end
      chk("mr_no_stale_valid", 32'(seen_v), 32'(0));
      chk("mr_no_stale_done",  32'(seen_d), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
